// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit and the MIPS datapath.
// The datapath supplies op/funct/zero; the control unit drives every select/enable.
interface multicycle_control_unit_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCen;
  logic       IorD;
  logic       Ori;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       PCsrc;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;

  modport master (
    input  op, funct, zero,
    output PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCsrc, ALUSrcB, ALUControl
  );

  modport slave (
    output op, funct, zero,
    input  PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCsrc, ALUSrcB, ALUControl
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq, addi, ori).
// Outputs decode the current state; write enables are gated off while reset is low.
module multicycle_control_unit #(
  parameter int unsigned STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_unit_if.master bus,
  output logic [STATE_W-1:0]        state_o,
  output logic                      illegal_o,
  output logic                      instr_done_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10
  } state_e;

  state_e     state_q, state_d;

  logic       pc_en, iord, ori, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_src, illegal, instr_done;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic       funct_legal;
  logic [2:0] funct_alu;

  // R-type funct decode; the IR holds funct stable across DECODE and RTEX
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = ALU_ADD;
    case (bus.funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = FETCH;
    pc_en      = 1'b0;
    iord       = 1'b0;
    ori        = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (bus.op == OP_LW || bus.op == OP_SW)          state_d = MEMADR;
        else if (bus.op == OP_RTYPE && funct_legal)      state_d = RTEX;
        else if (bus.op == OP_BEQ)                       state_d = BRANCH;
        else if (bus.op == OP_ADDI || bus.op == OP_ORI)  state_d = IEX;
        else begin
          state_d = FETCH;
          illegal = 1'b1;
        end
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_ctl   = funct_alu;
        state_d   = RTWB;
      end
      RTWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUB;
        pc_src     = 1'b1;
        pc_en      = bus.zero;
        instr_done = 1'b1;
      end
      IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.op == OP_ORI) begin
          alu_ctl = ALU_OR;
          ori     = 1'b1;
        end
        state_d = IWB;
      end
      IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Enables and pulses are held low during reset; selects keep their FETCH values
  assign bus.PCen       = pc_en     & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.IRWrite    = ir_write  & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign illegal_o      = illegal    & reset;
  assign instr_done_o   = instr_done & reset;
  assign bus.IorD       = iord;
  assign bus.Ori        = ori;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.PCsrc      = pc_src;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign state_o        = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table over an
// instruction stream, plus a hand-written mid-instruction reset sequence.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] state_o;
  logic       illegal_o;
  logic       instr_done_o;
  int         checks;
  int         errors;

  multicycle_control_unit_if u_if ();

  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (u_if),
    .state_o      (state_o),
    .illegal_o    (illegal_o),
    .instr_done_o (instr_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        ill;
    logic        done;
  } row_t;

  row_t rows[$];

  // {PCen,IorD,Ori,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCsrc,ALUSrcB,ALUControl}
  function automatic logic [14:0] ctl(input logic pcen, iord, ori, mw, irw, rd, mtr, rw,
                                      input logic sa, pcs, input logic [1:0] sb,
                                      input logic [2:0] alu);
    return {pcen, iord, ori, mw, irw, rd, mtr, rw, sa, pcs, sb, alu};
  endfunction

  function automatic logic [14:0] actual_ctl();
    return {u_if.PCen, u_if.IorD, u_if.Ori, u_if.MemWrite, u_if.IRWrite, u_if.RegDst,
            u_if.MemtoReg, u_if.RegWrite, u_if.ALUSrcA, u_if.PCsrc, u_if.ALUSrcB,
            u_if.ALUControl};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                      input logic [3:0] st, input logic [14:0] c, input logic ill,
                      input logic done);
    row_t r;
    r.op = op; r.funct = funct; r.zero = zero; r.st = st; r.ctl = c; r.ill = ill; r.done = done;
    rows.push_back(r);
  endtask

  logic [14:0] c_fetch, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_rtwb, c_iwb;

  task automatic fd(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                    input logic ill);
    push(op, funct, zero, 4'd0, c_fetch, 1'b0, 1'b0);
    push(op, funct, zero, 4'd1, c_dec, ill, 1'b0);
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [2:0] alu);
    fd(6'h00, funct, 1'b0, 1'b0);
    push(6'h00, funct, 1'b0, 4'd6, ctl(0,0,0,0,0,0,0,0,1,0,2'b00,alu), 1'b0, 1'b0);
    push(6'h00, funct, 1'b0, 4'd7, c_rtwb, 1'b0, 1'b1);
  endtask

  task automatic branch(input logic z);
    fd(6'h04, 6'h00, z, 1'b0);
    push(6'h04, 6'h00, z, 4'd8, ctl(z,0,0,0,0,0,0,0,1,1,2'b00,3'b110), 1'b0, 1'b1);
  endtask

  task automatic imm(input logic [5:0] op, input logic o, input logic [2:0] alu);
    fd(op, 6'h15, 1'b0, 1'b0);
    push(op, 6'h15, 1'b0, 4'd9, ctl(0,0,o,0,0,0,0,0,1,0,2'b10,alu), 1'b0, 1'b0);
    push(op, 6'h15, 1'b0, 4'd10, c_iwb, 1'b0, 1'b1);
  endtask

  task automatic check_now(input string tag, input logic [3:0] st, input logic [14:0] c,
                           input logic ill, input logic done);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctl"}, 32'(actual_ctl()), 32'(c));
    chk({tag, ".illegal"}, 32'(illegal_o), 32'(ill));
    chk({tag, ".done"}, 32'(instr_done_o), 32'(done));
    chk({tag, ".wr_mutex"},
        32'(32'(u_if.MemWrite) + 32'(u_if.RegWrite) + 32'(u_if.IRWrite) <= 1), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    u_if.op = 6'h00; u_if.funct = 6'h20; u_if.zero = 1'b0;

    c_fetch = ctl(1,0,0,0,1,0,0,0,0,0,2'b01,3'b010);
    c_dec   = ctl(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010);
    c_madr  = ctl(0,0,0,0,0,0,0,0,1,0,2'b10,3'b010);
    c_mrd   = ctl(0,1,0,0,0,0,0,0,0,0,2'b00,3'b010);
    c_mwb   = ctl(0,0,0,0,0,0,1,1,0,0,2'b00,3'b010);
    c_mwr   = ctl(0,1,0,1,0,0,0,0,0,0,2'b00,3'b010);
    c_rtwb  = ctl(0,0,0,0,0,1,0,1,0,0,2'b00,3'b010);
    c_iwb   = ctl(0,0,0,0,0,0,0,1,0,0,2'b00,3'b010);

    rtype(6'h22, 3'b110);
    fd(6'h23, 6'h00, 1'b0, 1'b0);
    push(6'h23, 6'h00, 1'b0, 4'd2, c_madr, 1'b0, 1'b0);
    push(6'h23, 6'h00, 1'b0, 4'd3, c_mrd, 1'b0, 1'b0);
    push(6'h23, 6'h00, 1'b0, 4'd4, c_mwb, 1'b0, 1'b1);
    fd(6'h2B, 6'h00, 1'b1, 1'b0);
    push(6'h2B, 6'h00, 1'b1, 4'd2, c_madr, 1'b0, 1'b0);
    push(6'h2B, 6'h00, 1'b1, 4'd5, c_mwr, 1'b0, 1'b1);
    branch(1'b1);
    branch(1'b0);
    imm(6'h0D, 1'b1, 3'b001);
    imm(6'h08, 1'b0, 3'b010);
    fd(6'h3F, 6'h20, 1'b0, 1'b1);
    fd(6'h00, 6'h08, 1'b0, 1'b1);
    rtype(6'h20, 3'b010);
    rtype(6'h24, 3'b000);
    rtype(6'h25, 3'b001);
    rtype(6'h2A, 3'b111);

    // Held in reset: FETCH state, enables low, selects at FETCH values
    #2;
    check_now("por", 4'd0, ctl(0,0,0,0,0,0,0,0,0,0,2'b01,3'b010), 1'b0, 1'b0);
    #20 reset = 1'b1;

    foreach (rows[i]) begin
      u_if.op = rows[i].op; u_if.funct = rows[i].funct; u_if.zero = rows[i].zero;
      #1;
      check_now($sformatf("row%0d", i), rows[i].st, rows[i].ctl, rows[i].ill, rows[i].done);
      @(posedge clk); #1;
    end

    // Reset asserted in RTEX for three cycles aborts the instruction
    u_if.op = 6'h00; u_if.funct = 6'h22; u_if.zero = 1'b0;
    #1 check_now("rst_f", 4'd0, c_fetch, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_now("rst_d", 4'd1, c_dec, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_now("rst_rtex", 4'd6, ctl(0,0,0,0,0,0,0,0,1,0,2'b00,3'b110), 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check_now($sformatf("rst_low%0d", k), 4'd0,
                   ctl(0,0,0,0,0,0,0,0,0,0,2'b01,3'b010), 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1 check_now("rst_rel", 4'd0, c_fetch, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_now("rst_dec", 4'd1, c_dec, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the multicycle MIPS datapath.
- Consumes op/funct from the instruction register and the ALU zero flag.
- Produces every datapath select/enable: PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCsrc, ALUControl.
- Sits directly upstream of the datapath; adds status outputs for debug/bench.

Parameters:
- STATE_W, 4, width of the state register and state_o.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  Instr[31:26]
- funct  in  6  Instr[5:0]
- zero  in  1  combinational ALU zero flag, valid in BRANCH
- PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCsrc  out  1 each  datapath controls
- ALUSrcB  out  2  00=B, 01=4, 10=SignExt, 11=SignExt<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state_o  out  STATE_W  current state encoding
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported op/funct
- instr_done_o  out  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Mux convention for all 1-bit selects: 0 selects the first input.
  - IorD 0=PC; RegDst 0=rt, 1=rd; MemtoReg 0=ALU_o, 1=memory data; ALUSrcA 0=PC, 1=A; PCsrc 0=ALUResult, 1=ALU_o.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, IEX=9, IWB=10.
  - Encodings 11-15 return to FETCH on the next edge.
- Reset (reset=0): state=FETCH immediately. PCen, MemWrite, IRWrite, RegWrite, illegal_o and instr_done_o are forced 0 while reset is low. All selects hold their FETCH values. First fetch happens on the first rising edge after release. Reset mid-instruction aborts it with no further writes.
- Default for every unlisted output in a state: 0, with ALUControl=010.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, add, PCsrc=0, PCen=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALU_o). Next state:
  - op 23h or 2Bh -> MEMADR
  - op 00h with legal funct -> RTEX
  - op 04h -> BRANCH
  - op 08h or 0Dh -> IEX
  - anything else -> FETCH, with illegal_o=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done_o=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1, instr_done_o=1 -> FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUControl from funct -> RTWB.
  - 20h add, 22h sub, 24h and, 25h or, 2Ah slt.
  - The decoded funct is held from the IR; IR is stable because IRWrite=0 outside FETCH.
- RTWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done_o=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCsrc=1, PCen=zero, instr_done_o=1 -> FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10 -> IWB.
  - addi (08h): add, Ori=0.
  - ori (0Dh): or, Ori=1 (immediate replaced by GPIO_i).
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done_o=1 -> FETCH. Ori stays 0 here.
- Latency in cycles, FETCH through the final state: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, illegal 2.
- Mutual exclusion: at most one of MemWrite, RegWrite, IRWrite is high in any cycle.
- zero is sampled only in BRANCH and ignored elsewhere.

Test Plan:
- Reset low for 3 cycles mid-RTEX, then release -> state_o=0 and all enables 0 during reset; first post-reset cycle shows FETCH with IRWrite=1, PCen=1.
- op=00h, funct=22h -> states 0,1,6,7. RTEX ALUControl=110. RTWB RegWrite=1, RegDst=1. instr_done_o high only in cycle 4.
- op=23h (lw) -> states 0,1,2,3,4. MEMRD IorD=1. MEMWB MemtoReg=1, RegWrite=1. MemWrite stays 0 throughout.
- op=04h (beq), once with zero=1 and once with zero=0 -> BRANCH has PCsrc=1, ALUControl=110, PCen=1 and 0 respectively. 3-cycle sequence.
- op=0Dh (ori) -> IEX has Ori=1, ALUControl=001, ALUSrcB=10. IWB RegWrite=1, RegDst=0, Ori=0.
- op=3Fh, and separately op=00h with funct=08h -> illegal_o pulses in DECODE. Next state is FETCH; RegWrite and MemWrite never assert.
